// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: drives imem_pc, tracks the single in-flight read and queues returns.
// Define IMEM_BOUND_CHECK_EN to trap fetches at or beyond DEPTH into a sticky FAULT state.
module fetch_sequencer #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 70,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_pc,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               halt_req,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  output logic               halted,
  output logic               fault
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;

  logic [1:0]         state;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    tag_pc;
  logic               inflight;
  logic               halt_pending;

  logic [INSTR_W-1:0] q_instr [2];
  logic [PC_W-1:0]    q_pc    [2];
  logic               rd_ptr;
  logic               wr_ptr;
  logic [1:0]         occ;

  logic               pop;
  logic               push;
  logic               space_ok;
  logic               can_issue;
  logic               issue;
  logic               redirect_take;
  logic               bound_bad;

`ifdef IMEM_BOUND_CHECK_EN
  localparam logic [1:0] ST_FAULT = 2'd2;

  // FAULT is terminal until reset, so redirects are not honoured there.
  assign redirect_take = redirect_valid && (state != ST_FAULT);
  assign bound_bad     = ({16'h0, fetch_pc} >= 32'(DEPTH));
  assign fault         = (state == ST_FAULT);
`else
  logic unused_depth;

  assign redirect_take = redirect_valid;
  assign bound_bad     = 1'b0;
  assign fault         = 1'b0;
  assign unused_depth  = ^DEPTH;
`endif

  // Decode handshake: a word transfers on every rising edge where out_valid && out_ready;
  // while out_valid && !out_ready the head (out_instr/out_pc) holds steady.
  assign out_valid = (occ != 2'd0);
  assign out_instr = q_instr[rd_ptr];
  assign out_pc    = q_pc[rd_ptr];
  assign pop       = out_valid && out_ready;

  assign imem_pc   = fetch_pc;
  assign halted    = (state == ST_HALT);

  // The in-flight word always lands at the next edge, so reserve room for it before issuing.
  assign space_ok  = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign can_issue = (state == ST_RUN) && !redirect_take && !halt_req && !halt_pending && space_ok;
  assign issue     = can_issue && !bound_bad;
  assign push      = inflight && !redirect_take;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_RUN;
      fetch_pc     <= RESET_PC;
      tag_pc       <= '0;
      inflight     <= 1'b0;
      halt_pending <= 1'b0;
      occ          <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      q_instr[0]   <= '0;
      q_instr[1]   <= '0;
      q_pc[0]      <= '0;
      q_pc[1]      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_pc <= fetch_pc;
      end

      if (redirect_take) begin
        fetch_pc <= redirect_pc;
      end else if (issue) begin
        fetch_pc <= fetch_pc + 1'b1;
      end

      if (redirect_take) begin
        occ    <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          q_instr[wr_ptr] <= imem_instr;
          q_pc[wr_ptr]    <= tag_pc;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        occ <= occ + {1'b0, push} - {1'b0, pop};
      end

      case (state)
        ST_RUN: begin
          if (redirect_take) begin
            state        <= halt_req ? ST_HALT : ST_RUN;
            halt_pending <= 1'b0;
          end else if (halt_req || halt_pending) begin
            // Wait for the outstanding read to land before reporting HALT.
            if (inflight) begin
              halt_pending <= 1'b1;
            end else begin
              state        <= ST_HALT;
              halt_pending <= 1'b0;
            end
          end
`ifdef IMEM_BOUND_CHECK_EN
          else if (can_issue && bound_bad) begin
            state <= ST_FAULT;
          end
`endif
        end
        ST_HALT: begin
          if (redirect_take) begin
            state <= halt_req ? ST_HALT : ST_RUN;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory word i holds 0x1000_0000+i, read latency one cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        halt_req;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        halted;
  logic        fault;

  int n_vec = 0;
  int n_err = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted),
    .fault          (fault)
  );

  // Clock and synchronous memory model.
  always #5 clk = ~clk;

  always @(posedge clk) imem_instr <= 32'h1000_0000 + {16'h0000, imem_pc};

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exhausted, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change only at the falling edge, outputs are read there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    out_ready      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic wait_head(input logic [15:0] pc);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid === 1'b1 && out_pc === pc) seen = 1;
      else step();
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_head: pc %h never reached head (got %h valid %b)", pc, out_pc, out_valid);
    end
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0;
    halt_req       = 1'b0;
    out_ready      = 1'b1;
    step();
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 16'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0000", out_pc); end
    n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    n_vec++; if (imem_pc !== 16'h0) begin n_err++; $display("FAIL reset_imem_pc: got %h want 0000", imem_pc); end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted); end
    n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault: got %b want 0", fault); end
  endtask

  task automatic test_stream();
    logic [15:0] exp_pc;
    do_reset();
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_latency: got %b want 0", out_valid); end
    step();
    for (int k = 0; k < 8; k++) begin
      exp_pc = 16'(k);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid); end
      n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL stream_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
      n_vec++; if (out_instr !== 32'h1000_0000 + {16'h0, exp_pc}) begin
        n_err++; $display("FAIL stream_instr[%0d]: got %h want %h", k, out_instr, 32'h1000_0000 + {16'h0, exp_pc});
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_pc;
    do_reset();
    wait_head(16'd3);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", i, out_valid); end
      n_vec++; if (out_pc !== 16'd3) begin n_err++; $display("FAIL bp_hold_pc[%0d]: got %h want 0003", i, out_pc); end
      n_vec++; if (out_instr !== 32'h1000_0003) begin n_err++; $display("FAIL bp_hold_instr[%0d]: got %h want 10000003", i, out_instr); end
    end
    out_ready = 1'b1;
    for (int k = 3; k < 9; k++) begin
      exp_pc = 16'(k);
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_resume_valid[%0d]: got %b want 1", k, out_valid); end
      n_vec++; if (out_pc !== exp_pc) begin n_err++; $display("FAIL bp_resume_pc[%0d]: got %h want %h", k, out_pc, exp_pc); end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    wait_head(16'd4);
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    step();
    redirect_valid = 1'b0;
    out_ready      = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_flush: got valid %b pc %h want 0", out_valid, out_pc); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL redir_killed: got valid %b pc %h want 0", out_valid, out_pc); end
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL redir_valid: got %b want 1", out_valid); end
    n_vec++; if (out_pc !== 16'h0020) begin n_err++; $display("FAIL redir_pc: got %h want 0020", out_pc); end
    n_vec++; if (out_instr !== 32'h1000_0020) begin n_err++; $display("FAIL redir_instr: got %h want 10000020", out_instr); end
    step();
    n_vec++; if (out_pc !== 16'h0021) begin n_err++; $display("FAIL redir_next_pc: got %h want 0021", out_pc); end
  endtask

  task automatic test_halt();
    do_reset();
    wait_head(16'd7);
    halt_req = 1'b1;
    step();
    halt_req = 1'b0;
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'd8) begin
      n_err++; $display("FAIL halt_drain: got valid %b pc %h want 1/0008", out_valid, out_pc);
    end
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_early: got %b want 0", halted); end
    step();
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_state: got %b want 1", halted); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_empty: got %b want 0", out_valid); end
    n_vec++; if (imem_pc !== 16'd9) begin n_err++; $display("FAIL halt_imem_pc: got %h want 0009", imem_pc); end
    step(); step(); step();
    n_vec++; if (imem_pc !== 16'd9 || halted !== 1'b1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL halt_hold: got pc %h halted %b valid %b want 0009/1/0", imem_pc, halted, out_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0002;
    step();
    redirect_valid = 1'b0;
    n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_exit: got %b want 0", halted); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL halt_resume_lat: got %b want 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0002 || out_instr !== 32'h1000_0002) begin
      n_err++; $display("FAIL halt_resume: got valid %b pc %h instr %h want 1/0002/10000002", out_valid, out_pc, out_instr);
    end
    step();
    n_vec++; if (out_pc !== 16'h0003) begin n_err++; $display("FAIL halt_resume_next: got %h want 0003", out_pc); end
  endtask

  task automatic test_redirect_halt();
    do_reset();
    wait_head(16'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0010;
    halt_req       = 1'b1;
    step();
    redirect_valid = 1'b0;
    halt_req       = 1'b0;
    n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL rh_halted: got %b want 1", halted); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rh_flush: got %b want 0", out_valid); end
    n_vec++; if (imem_pc !== 16'h0010) begin n_err++; $display("FAIL rh_pc: got %h want 0010", imem_pc); end
    step(); step();
    n_vec++; if (imem_pc !== 16'h0010 || out_valid !== 1'b0 || halted !== 1'b1) begin
      n_err++; $display("FAIL rh_hold: got pc %h valid %b halted %b want 0010/0/1", imem_pc, out_valid, halted);
    end
  endtask

`ifdef IMEM_BOUND_CHECK_EN
  task automatic test_bound();
    do_reset();
    wait_head(16'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'd68;
    step();
    redirect_valid = 1'b0;
    step(); step();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'd68 || fault !== 1'b0) begin
      n_err++; $display("FAIL bound_68: got valid %b pc %h fault %b want 1/0044/0", out_valid, out_pc, fault);
    end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'd69) begin
      n_err++; $display("FAIL bound_69: got valid %b pc %h want 1/0045", out_valid, out_pc);
    end
    n_vec++; if (fault !== 1'b1) begin n_err++; $display("FAIL bound_fault: got %b want 1", fault); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bound_drained: got %b want 0", out_valid); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'd0;
    step();
    redirect_valid = 1'b0;
    step(); step();
    n_vec++; if (out_valid !== 1'b0 || fault !== 1'b1 || imem_pc !== 16'd70) begin
      n_err++; $display("FAIL bound_sticky: got valid %b fault %b pc %h want 0/1/0046", out_valid, fault, imem_pc);
    end
  endtask
`else
  task automatic test_pc_wrap();
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'hFFFE;
    exp_pc[1] = 16'hFFFF;
    exp_pc[2] = 16'h0000;
    exp_pc[3] = 16'h0001;
    do_reset();
    wait_head(16'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    step(); step();
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (out_valid !== 1'b1 || out_pc !== exp_pc[k]) begin
        n_err++; $display("FAIL wrap_pc[%0d]: got valid %b pc %h want 1/%h", k, out_valid, out_pc, exp_pc[k]);
      end
      n_vec++; if (out_instr !== 32'h1000_0000 + {16'h0, exp_pc[k]}) begin
        n_err++; $display("FAIL wrap_instr[%0d]: got %h want %h", k, out_instr, 32'h1000_0000 + {16'h0, exp_pc[k]});
      end
      step();
    end
  endtask
`endif

  task automatic test_reset_full();
    do_reset();
    wait_head(16'd3);
    out_ready = 1'b0;
    step(); step(); step();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'd3) begin
      n_err++; $display("FAIL rf_full: got valid %b pc %h want 1/0003", out_valid, out_pc);
    end
    reset = 1'b1;
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_valid: got %b want 0", out_valid); end
    n_vec++; if (out_pc !== 16'h0 || out_instr !== 32'h0) begin
      n_err++; $display("FAIL rf_outputs: got pc %h instr %h want 0000/0", out_pc, out_instr);
    end
    n_vec++; if (imem_pc !== 16'h0) begin n_err++; $display("FAIL rf_imem_pc: got %h want 0000", imem_pc); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_latency: got %b want 0", out_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 16'h0 || out_instr !== 32'h1000_0000) begin
      n_err++; $display("FAIL rf_restart: got valid %b pc %h instr %h want 1/0000/10000000", out_valid, out_pc, out_instr);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_redirect_halt();
`ifdef IMEM_BOUND_CHECK_EN
    test_bound();
`else
    test_pc_wrap();
`endif
    test_reset_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
